// File: rtl/ks_vec_adder_pipe.sv
// ks_vec_adder_pipe: two-stage lane-segmented Kogge-Stone add/sub with valid/ready handshake
//   Optional macro KS_VEC_SAT_EN enables per-lane unsigned/signed saturation in stage 2.
//   clk, rst_n      : clock, synchronous active-low reset
//   in_valid/ready  : operand beat handshake (a, b, cin, sub, lane_mode, sat)
//   out_valid/ready : result handshake (sum, cout, ovf)
//   lane_mode       : 00/01/10/11 = 8/16/32/64-bit lanes, clamped to DATA_W
//   cout, ovf       : per-granule flags, non-zero only at each lane's MSB granule
module ks_vec_adder_pipe #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  cin,
    input  logic                  sub,
    input  logic [1:0]            lane_mode,
    input  logic [1:0]            sat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     sum,
    output logic [DATA_W/8-1:0]   cout,
    output logic [DATA_W/8-1:0]   ovf
);
    localparam int GRAN = DATA_W / 8;
    localparam int LVL = $clog2(DATA_W);
    localparam logic [1:0] MAXM = 2'($clog2(GRAN));
    logic s1_valid, s2_ready, s1_c;
    logic [DATA_W-1:0] s1_p, s1_g, b_eff;
    logic [1:0] s1_mode, mode_in;
    logic [GRAN-1:0] glsb, gmsb, cout_n, ovf_n;
    logic [DATA_W-1:0] lsb, ci, co, sum_n, res;
    logic [LVL:0][DATA_W-1:0] gg;
    logic [LVL-1:0][DATA_W-1:0] pp;
    int lg;
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign b_eff = sub ? ~b : b;
    assign mode_in = (lane_mode > MAXM) ? MAXM : lane_mode;
`ifdef KS_VEC_SAT_EN
    logic [1:0] s1_sat;
    logic s1_sub;
    logic [GRAN-1:0] s1_amsb;
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sat <= sat;
            s1_sub <= sub;
            for (int j = 0; j < GRAN; j++) s1_amsb[j] <= a[8*j+7];
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^sat;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_p <= a ^ b_eff;
            s1_g <= a & b_eff;
            s1_c <= sub ? 1'b1 : cin;
            s1_mode <= mode_in;
        end
    end
    always_comb begin
        lg = 1 << s1_mode;
        for (int j = 0; j < GRAN; j++) begin
            glsb[j] = (j & (lg - 1)) == 0;
            gmsb[j] = ((j + 1) & (lg - 1)) == 0;
        end
        // Lane-LSB bits absorb the lane carry-in and get P=0, so no group
        // prefix can see past a lane boundary and the tree needs no extra kill.
        for (int i = 0; i < DATA_W; i++) begin
            lsb[i] = (i % 8 == 0) && glsb[i/8];
            gg[0][i] = s1_g[i] | (lsb[i] & s1_p[i] & s1_c);
            pp[0][i] = s1_p[i] & ~lsb[i];
        end
        for (int k = 0; k < LVL - 1; k++) pp[k+1] = pp[k] & (pp[k] << (1 << k));
        for (int k = 0; k < LVL; k++) gg[k+1] = gg[k] | (pp[k] & (gg[k] << (1 << k)));
        co = gg[LVL];
        ci = (lsb & {DATA_W{s1_c}}) | (~lsb & (co << 1));
        sum_n = s1_p ^ ci;
        for (int j = 0; j < GRAN; j++) begin
            cout_n[j] = gmsb[j] & co[8*j+7];
            ovf_n[j] = gmsb[j] & (co[8*j+7] ^ ci[8*j+7]);
        end
`ifdef KS_VEC_SAT_EN
        for (int j = 0; j < GRAN; j++) begin
            // m: index of the MSB granule of the lane containing granule j
            res[8*j +: 8] = (s1_sat == 2'b01 && (s1_sub ? !cout_n[j | (lg - 1)] : cout_n[j | (lg - 1)])) ? (s1_sub ? 8'h00 : 8'hFF)
                          : (s1_sat == 2'b10 && ovf_n[j | (lg - 1)]) ? ((j == (j | (lg - 1))) ? (s1_amsb[j | (lg - 1)] ? 8'h80 : 8'h7F)
                                                                                           : (s1_amsb[j | (lg - 1)] ? 8'h00 : 8'hFF))
                          : sum_n[8*j +: 8];
        end
`else
        res = sum_n;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum <= '0;
            cout <= '0;
            ovf <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum <= res;
                cout <= cout_n;
                ovf <= ovf_n;
            end
        end
    end
endmodule

// File: tb/tb_ks_vec_adder_pipe.sv
// tb_ks_vec_adder_pipe: scoreboard bench with directed vectors, back-pressure and mid-stall reset
module tb_ks_vec_adder_pipe;
    logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 1;
    logic in_ready, out_valid;
    logic [31:0] a = 0, b = 0, sum;
    logic [1:0] lane_mode = 0, sat = 0;
    logic [3:0] cout, ovf;
    typedef struct {
        logic [31:0] s;
        logic [3:0] c;
        logic [3:0] o;
        int acc;
        bit lat;
    } exp_t;
    exp_t q[$];
    int compared = 0, mism = 0, cyc = 0;
`ifdef KS_VEC_SAT_EN
    localparam logic [31:0] SAT_A = 32'h000000FF, SAT_B = 32'h00000080;
`else
    localparam logic [31:0] SAT_A = 32'h00000000, SAT_B = 32'h0000007F;
`endif
    ks_vec_adder_pipe #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .lane_mode(lane_mode), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mism++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts,
                        input logic [1:0] tm, input logic [1:0] tsat, input logic [31:0] es,
                        input logic [3:0] ec, input logic [3:0] eo, input bit lat);
        exp_t e;
        int n = 0;
        a = ta; b = tb; cin = tc; sub = ts; lane_mode = tm; sat = tsat; in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {63'd0, in_ready}, 64'd1);
        if (in_ready) begin
            e = '{es, ec, eo, cyc, lat};
            q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask
    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("extra_output", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("result", {24'd0, sum, cout, ovf}, {24'd0, e.s, e.c, e.o});
                if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_outputs", {24'd0, sum, cout, ovf}, 64'd0);
        rst_n = 1;
        send(32'h01FF7F80, 32'h01018080, 0, 0, 2'b00, 2'b00, 32'h0200FF00, 4'b0101, 4'b0001, 1);
        send(32'hFFFFFFFF, 32'h00000001, 0, 0, 2'b10, 2'b00, 32'h00000000, 4'b1000, 4'b0000, 1);
        send(32'hFFFFFFFF, 32'h00000001, 0, 0, 2'b11, 2'b00, 32'h00000000, 4'b1000, 4'b0000, 1);
        send(32'h00050003, 32'h00060001, 0, 1, 2'b01, 2'b00, 32'hFFFF0002, 4'b0010, 4'b0000, 1);
        send(32'h0000FFFF, 32'h00000000, 1, 0, 2'b01, 2'b00, 32'h00010000, 4'b0010, 4'b0000, 1);
        send(32'h7F7F7F7F, 32'h00000000, 1, 0, 2'b00, 2'b00, 32'h80808080, 4'b0000, 4'b1111, 1);
        send(32'h00000005, 32'h00000007, 1, 1, 2'b10, 2'b00, 32'hFFFFFFFE, 4'b0000, 4'b0000, 1);
        send(32'h000000FF, 32'h00000001, 0, 0, 2'b00, 2'b01, SAT_A, 4'b0001, 4'b0000, 1);
        send(32'h00000080, 32'h00000001, 0, 1, 2'b00, 2'b10, SAT_B, 4'b1111, 4'b0001, 1);
        wait_empty();
        out_ready = 0;
        fork
            for (int k = 0; k < 4; k++)
                send(32'(k) * 32'h01010101, 32'h01010101, 0, 0, 2'b00, 2'b00, 32'(k + 1) * 32'h01010101, 4'b0000, 4'b0000, 0);
            begin
                repeat (3) @(negedge clk);
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("stream_rate", {63'd0, out_valid}, 64'd1);
                end
            end
        join
        wait_empty();
        out_ready = 0;
        send(32'hFF7F7F7F, 32'h01010101, 0, 0, 2'b00, 2'b00, 32'h00808080, 4'b1000, 4'b0111, 0);
        send(32'h01FF7F80, 32'h01018080, 0, 0, 2'b00, 2'b00, 32'h0200FF00, 4'b0101, 4'b0001, 0);
        chk("full_out_valid", {63'd0, out_valid}, 64'd1);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        q.delete();
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_outputs", {24'd0, sum, cout, ovf}, 64'd0);
        out_ready = 1;
        send(32'h00050003, 32'h00060001, 0, 1, 2'b01, 2'b00, 32'hFFFF0002, 4'b0010, 4'b0000, 1);
        wait_empty();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
